// File: rtl/frame_drawer_pkg.sv
// Shared types and sizes for the rectangle fill / sprite blit engine.
// Optional build macro: FRAME_DRAWER_TRANSPARENCY_EN (see frame_drawer).
package frame_drawer_pkg;

   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int FB_ADDR_W = 19;
   localparam int PIX_W     = 8;
   localparam int CRD_W     = 10;
   localparam int SPR_W     = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLIP,
      S_DRAW,
      S_FINISH
   } state_t;

   typedef struct packed {
      logic             mode;
      logic [CRD_W-1:0] x;
      logic [CRD_W-1:0] y;
      logic [CRD_W-1:0] w;
      logic [CRD_W-1:0] h;
      logic [PIX_W-1:0] color;
      logic [SPR_W-1:0] base;
   } draw_cmd_t;

   // Length of a span starting at pos, cut at the screen edge lim.
   function automatic logic [CRD_W-1:0] clip_len(
      input logic [CRD_W-1:0] pos,
      input logic [CRD_W-1:0] len,
      input logic [CRD_W:0]   lim
   );
      logic [CRD_W:0] room;
      room = lim - {1'b0, pos};
      return ({1'b0, len} > room) ? room[CRD_W-1:0] : len;
   endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Row/column walker for frame_drawer: clipped extents, frame address
// and sprite address, stepping one pixel per cycle while active.
module frame_addr_gen
   import frame_drawer_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 load,
   input  logic [CRD_W-1:0]     x,
   input  logic [CRD_W-1:0]     y,
   input  logic [CRD_W-1:0]     w,
   input  logic [CRD_W-1:0]     h,
   input  logic [SPR_W-1:0]     base,
   output logic                 empty,
   output logic                 active,
   output logic [FB_ADDR_W-1:0] fb_addr,
   output logic [SPR_W-1:0]     sprite_addr
);

   localparam logic [CRD_W:0]     H_LIM = (CRD_W+1)'(H_RES);
   localparam logic [CRD_W:0]     V_LIM = (CRD_W+1)'(V_RES);
   localparam logic [FB_ADDR_W-1:0] H_FB = FB_ADDR_W'(H_RES);

   logic [CRD_W-1:0]     col;
   logic [CRD_W-1:0]     row;
   logic [CRD_W-1:0]     eff_w;
   logic [CRD_W-1:0]     eff_h;
   logic [CRD_W-1:0]     stride;
   logic [SPR_W-1:0]     spr_row;
   logic [SPR_W-1:0]     next_row;
   logic [FB_ADDR_W-1:0] row_base;
   logic [FB_ADDR_W-1:0] wrap_step;
   logic                 col_last;
   logic                 row_last;

   always_comb begin
      empty     = ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM) ||
                  (w == '0) || (h == '0);
      row_base  = FB_ADDR_W'(y) * H_FB + FB_ADDR_W'(x);
      wrap_step = H_FB - FB_ADDR_W'(eff_w) + FB_ADDR_W'(1);
      // Sprite rows advance by the unclipped width.
      next_row  = spr_row + SPR_W'(stride);
      col_last  = (col == eff_w - CRD_W'(1));
      row_last  = (row == eff_h - CRD_W'(1));
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         col         <= '0;
         row         <= '0;
         eff_w       <= '0;
         eff_h       <= '0;
         stride      <= '0;
         spr_row     <= '0;
         sprite_addr <= '0;
         fb_addr     <= '0;
         active      <= 1'b0;
      end else if (load) begin
         col         <= '0;
         row         <= '0;
         eff_w       <= clip_len(x, w, H_LIM);
         eff_h       <= clip_len(y, h, V_LIM);
         stride      <= w;
         spr_row     <= base;
         sprite_addr <= base;
         fb_addr     <= row_base;
         active      <= !empty;
      end else if (active) begin
         if (col_last) begin
            col         <= '0;
            fb_addr     <= fb_addr + wrap_step;
            spr_row     <= next_row;
            sprite_addr <= next_row;
            if (row_last)
               active <= 1'b0;
            else
               row <= row + CRD_W'(1);
         end else begin
            col         <= col + CRD_W'(1);
            fb_addr     <= fb_addr + FB_ADDR_W'(1);
            sprite_addr <= sprite_addr + SPR_W'(1);
         end
      end
   end

endmodule

// File: rtl/frame_drawer.sv
// Clipped rectangle fill / sprite copy into a frame buffer, one pixel
// per cycle. FRAME_DRAWER_TRANSPARENCY_EN skips TRANSPARENT_KEY pixels.
module frame_drawer
   import frame_drawer_pkg::*;
#(
   parameter int               H_RES           = H_RES_DEF,
   parameter int               V_RES           = V_RES_DEF,
   parameter logic [PIX_W-1:0] TRANSPARENT_KEY = 8'hE3
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_mode,
   input  logic [CRD_W-1:0]     cmd_x,
   input  logic [CRD_W-1:0]     cmd_y,
   input  logic [CRD_W-1:0]     cmd_w,
   input  logic [CRD_W-1:0]     cmd_h,
   input  logic [PIX_W-1:0]     cmd_color,
   input  logic [SPR_W-1:0]     cmd_sprite_base,
   output logic [SPR_W-1:0]     sprite_addr,
   input  logic [PIX_W-1:0]     sprite_data,
   output logic [PIX_W-1:0]     frame_input,
   output logic [FB_ADDR_W-1:0] frame_wrAddress,
   output logic                 frame_we,
   output logic                 busy,
   output logic                 done
);

   state_t               state;
   state_t               state_nx;
   draw_cmd_t            cmd_q;
   logic                 load;
   logic                 empty;
   logic                 active;
   logic [FB_ADDR_W-1:0] fb_addr;
   logic                 wr_valid;

   frame_addr_gen #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_addr (
      .Clk         (Clk),
      .Reset       (Reset),
      .load        (load),
      .x           (cmd_q.x),
      .y           (cmd_q.y),
      .w           (cmd_q.w),
      .h           (cmd_q.h),
      .base        (cmd_q.base),
      .empty       (empty),
      .active      (active),
      .fb_addr     (fb_addr),
      .sprite_addr (sprite_addr)
   );

   always_ff @(posedge Clk) begin
      if (Reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (cmd_valid) state_nx = S_CLIP;
         S_CLIP:   state_nx = empty ? S_FINISH : S_DRAW;
         S_DRAW:   if (!active) state_nx = S_FINISH;
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      unique case (state)
         S_IDLE:   cmd_ready = 1'b1;
         S_CLIP: begin
            busy = 1'b1;
            load = 1'b1;
         end
         S_DRAW:   busy = 1'b1;
         S_FINISH: done = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cmd_q <= '0;
      end else if (cmd_valid && cmd_ready) begin
         cmd_q <= '{mode:  cmd_mode,
                    x:     cmd_x,
                    y:     cmd_y,
                    w:     cmd_w,
                    h:     cmd_h,
                    color: cmd_color,
                    base:  cmd_sprite_base};
      end
   end

   // Write stage trails the issue stage by one cycle to meet ROM latency.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_valid        <= 1'b0;
         frame_wrAddress <= '0;
      end else begin
         wr_valid        <= (state == S_DRAW) && active;
         frame_wrAddress <= fb_addr;
      end
   end

   always_comb begin
      frame_input = '0;
      if (wr_valid)
         frame_input = cmd_q.mode ? sprite_data : cmd_q.color;
`ifdef FRAME_DRAWER_TRANSPARENCY_EN
      frame_we = wr_valid &&
                 !(cmd_q.mode && (sprite_data == TRANSPARENT_KEY));
`else
      frame_we = wr_valid;
`endif
   end

endmodule

// File: tb/tb_frame_drawer.sv
// Directed plus random command bench for frame_drawer with a
// pixel-list reference model and a one-cycle-latency sprite ROM.
module tb_frame_drawer;

   localparam int         H   = 640;
   localparam int         V   = 480;
   localparam logic [7:0] KEY = 8'hE3;
`ifdef FRAME_DRAWER_TRANSPARENCY_EN
   localparam bit TRANSP = 1'b1;
`else
   localparam bit TRANSP = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_mode = 1'b0;
   logic [9:0]  cmd_x = '0;
   logic [9:0]  cmd_y = '0;
   logic [9:0]  cmd_w = '0;
   logic [9:0]  cmd_h = '0;
   logic [7:0]  cmd_color = '0;
   logic [15:0] cmd_sprite_base = '0;
   logic [15:0] sprite_addr;
   logic [7:0]  sprite_data = '0;
   logic [7:0]  frame_input;
   logic [18:0] frame_wrAddress;
   logic        frame_we;
   logic        busy;
   logic        done;

   frame_drawer dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_mode        (cmd_mode),
      .cmd_x           (cmd_x),
      .cmd_y           (cmd_y),
      .cmd_w           (cmd_w),
      .cmd_h           (cmd_h),
      .cmd_color       (cmd_color),
      .cmd_sprite_base (cmd_sprite_base),
      .sprite_addr     (sprite_addr),
      .sprite_data     (sprite_data),
      .frame_input     (frame_input),
      .frame_wrAddress (frame_wrAddress),
      .frame_we        (frame_we),
      .busy            (busy),
      .done            (done)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   logic [7:0] rom [0:65535];
   always @(posedge Clk) sprite_data <= rom[sprite_addr];

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   typedef struct {
      logic       mode;
      int         x;
      int         y;
      int         w;
      int         h;
      logic [7:0] color;
      logic [15:0] base;
   } cmd_t;

   wr_t obs_q[$];
   int  done_q[$];
   int  busy_q[$];

   always @(negedge Clk) begin
      if (frame_we)
         obs_q.push_back('{int'(frame_wrAddress), int'(frame_input), cyc});
      if (done)
         done_q.push_back(cyc);
      if (busy)
         busy_q.push_back(cyc);
   end

   int passed = 0;
   int failed = 0;
   int total  = 0;

   task automatic check(input string tag, input longint obs,
                        input longint exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input cmd_t c, output int acc);
      cmd_mode        = c.mode;
      cmd_x           = 10'(c.x);
      cmd_y           = 10'(c.y);
      cmd_w           = 10'(c.w);
      cmd_h           = 10'(c.h);
      cmd_color       = c.color;
      cmd_sprite_base = c.base;
      cmd_valid       = 1'b1;
      for (int t = 0; t < 3000 && !cmd_ready; t++)
         @(negedge Clk);
      check("accept", longint'(cmd_ready), 1);
      acc = cyc;
   endtask

   // Expected pixel list from the clipping rules; cut >= 0 drops
   // everything after that cycle (reset abort) and expects no done.
   task automatic verify(input cmd_t c, input int acc, input int cut,
                         input string tag);
      wr_t        e[$];
      int         slot, ew, eh, done_at, win_end, n_obs, nd, first_d, nb, j;
      logic [7:0] d;
      slot = 0;
      if (c.x >= H || c.y >= V || c.w == 0 || c.h == 0) begin
         done_at = acc + 2;
      end else begin
         ew = (c.w < H - c.x) ? c.w : H - c.x;
         eh = (c.h < V - c.y) ? c.h : V - c.y;
         for (int r = 0; r < eh; r++) begin
            for (int k = 0; k < ew; k++) begin
               d = c.mode ? rom[16'(c.base + r * c.w + k)] : c.color;
               if (!(TRANSP && c.mode && d == KEY) &&
                   (cut < 0 || acc + 3 + slot <= cut))
                  e.push_back('{(c.y + r) * H + c.x + k, int'(d),
                                acc + 3 + slot});
               slot++;
            end
         end
         done_at = acc + 3 + slot;
      end
      win_end = (cut >= 0) ? cut + 3 : done_at;
      while (cyc <= win_end + 1)
         @(negedge Clk);
      j = 0;
      n_obs = 0;
      foreach (obs_q[i]) begin
         if (obs_q[i].cyc >= acc && obs_q[i].cyc <= win_end) begin
            n_obs++;
            if (j < e.size()) begin
               check({tag, " addr"}, obs_q[i].addr, e[j].addr);
               check({tag, " data"}, obs_q[i].data, e[j].data);
               check({tag, " cycle"}, obs_q[i].cyc - acc, e[j].cyc - acc);
               j++;
            end
         end
      end
      check({tag, " writes"}, n_obs, e.size());
      nd = 0;
      first_d = -1;
      foreach (done_q[i])
         if (done_q[i] >= acc && done_q[i] <= win_end) begin
            if (nd == 0) first_d = done_q[i];
            nd++;
         end
      if (cut < 0) begin
         check({tag, " done count"}, nd, 1);
         check({tag, " done cycle"}, first_d - acc, done_at - acc);
         nb = 0;
         foreach (busy_q[i])
            if (busy_q[i] >= acc && busy_q[i] <= win_end) nb++;
         check({tag, " busy cycles"}, nb, (slot == 0) ? 1 : slot + 2);
      end else begin
         check({tag, " done count"}, nd, 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t c;
      cmd_t c2;
      int   acc;
      int   acc2;

      for (int i = 0; i < 65536; i++)
         rom[i] = 8'($urandom);
      rom[100] = 8'hAA;
      rom[101] = 8'hE3;
      rom[102] = 8'hBB;
      rom[103] = 8'hCC;

      repeat (3) @(negedge Clk);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst we", frame_we, 0);
      check("rst wraddr", frame_wrAddress, 0);
      check("rst input", frame_input, 0);
      check("rst spraddr", sprite_addr, 0);
      Reset = 1'b0;
      @(negedge Clk);
      check("rst ready", cmd_ready, 1);

      c = '{1'b0, 10, 20, 3, 2, 8'h1C, 16'd0};
      send(c, acc);
      @(negedge Clk);
      cmd_valid = 1'b0;
      verify(c, acc, -1, "fill");

      c = '{1'b1, 0, 0, 4, 1, 8'h00, 16'd100};
      send(c, acc);
      @(negedge Clk);
      cmd_valid = 1'b0;
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
         check("spr issue addr", sprite_addr, 100 + k);
         @(negedge Clk);
      end
      verify(c, acc, -1, "sprite");

      c = '{1'b0, 638, 479, 5, 3, 8'h55, 16'd0};
      send(c, acc);
      @(negedge Clk);
      cmd_valid = 1'b0;
      verify(c, acc, -1, "clip");

      c = '{1'b0, 640, 5, 5, 2, 8'h11, 16'd0};
      send(c, acc);
      @(negedge Clk);
      cmd_valid = 1'b0;
      verify(c, acc, -1, "x640");

      c = '{1'b0, 5, 5, 0, 2, 8'h22, 16'd0};
      send(c, acc);
      @(negedge Clk);
      cmd_valid = 1'b0;
      verify(c, acc, -1, "w0");

      c  = '{1'b0, 100, 50, 100, 1, 8'h33, 16'd0};
      c2 = '{1'b0, 300, 60, 4, 2, 8'h44, 16'd0};
      send(c, acc);
      @(negedge Clk);
      send(c2, acc2);
      @(negedge Clk);
      cmd_valid = 1'b0;
      check("hold accept cycle", acc2 - acc, 3 + 100 + 1);
      verify(c, acc, -1, "hold first");
      verify(c2, acc2, -1, "hold second");

      c = '{1'b0, 0, 100, 200, 1, 8'h66, 16'd0};
      send(c, acc);
      @(negedge Clk);
      cmd_valid = 1'b0;
      while (cyc < acc + 10)
         @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("abort we", frame_we, 0);
      check("abort busy", busy, 0);
      verify(c, acc, acc + 10, "abort");
      c = '{1'b1, 20, 30, 6, 3, 8'h00, 16'hFFF0};
      send(c, acc);
      @(negedge Clk);
      cmd_valid = 1'b0;
      verify(c, acc, -1, "after abort");

      for (int n = 0; n < 16; n++) begin
         c.mode  = 1'($urandom);
         c.x     = int'($urandom_range(0, 700));
         c.y     = int'($urandom_range(0, 520));
         c.w     = int'($urandom_range(0, 40));
         c.h     = int'($urandom_range(0, 6));
         c.color = 8'($urandom);
         c.base  = 16'($urandom);
         if (n % 4 == 0) begin
            c.x = int'($urandom_range(620, 639));
            c.y = int'($urandom_range(470, 479));
         end
         send(c, acc);
         @(negedge Clk);
         cmd_valid = 1'b0;
         verify(c, acc, -1, "random");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
